dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words in the data array (power of two, 4..4096).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to rsp_valid assertion (1..15).
REQ-003 SHALL use one clock and synchronous active-high reset, decided as: clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 active  input  1  enable; when low no new request is accepted.
REQ-007 req_valid  input  1  initiator presents a request.
REQ-008 req_ready  output  1  responder can accept a request this cycle.
REQ-009 req_write  input  1  1 = store, 0 = load.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data.
REQ-012 req_wstrb  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7:8i).
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  initiator accepts the response.
REQ-015 rsp_rdata  output  32  load data; zero for stores and errors.
REQ-016 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-017 SHALL implement states IDLE, BUSY, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE with active=1; a request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-019 On acceptance SHALL register req_write, req_addr, req_wdata and req_wstrb; later input changes have no effect on the accepted request.
REQ-020 On acceptance SHALL go to RESP if LATENCY=1, otherwise to BUSY with the wait counter loaded to LATENCY-1.
REQ-021 In BUSY SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 1, so rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-022 SHALL commit stores and capture load data on the edge entering RESP; only enabled byte lanes are written.
REQ-023 In RESP SHALL hold rsp_valid=1 and rsp_rdata/rsp_err stable until an edge with rsp_ready=1, then go to IDLE.
REQ-024 SHALL keep at most one request outstanding; there is no request pipelining, and req_ready=0 in BUSY and RESP.
REQ-025 SHALL set rsp_err=1 for addr[1:0]!=0 or addr[31:2]>=DEPTH; an erroring store SHALL NOT modify the array, and rsp_rdata SHALL be 0.
REQ-026 SHALL index the array with addr[log2(DEPTH)+1:2]; there is no wrap-around, because out-of-range addresses error.
REQ-027 A store with req_wstrb=0000 SHALL complete normally with rsp_err=0 and leave the array unchanged.
REQ-028 active=0 SHALL only block acceptance; an already accepted request SHALL complete normally.
REQ-029 A load following a completed store to the same word SHALL return the merged stored data.
REQ-030 rsp_valid SHALL be 0 in IDLE and BUSY, and rsp_rdata/rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-031 On reset=1 at a rising edge SHALL enter IDLE, clear the counter and set rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready follows active in the next cycle.
REQ-032 Reset asserted in BUSY SHALL abort the request, and an uncommitted store SHALL NOT modify the array.
REQ-033 Array contents SHALL NOT be cleared by reset.
REQ-034 Reset SHALL take priority over a simultaneous acceptance or response handshake.

Verification
REQ-035 Store 0xDEADBEEF to addr 0x10 with wstrb=1111, then load 0x10 with LATENCY=2 -> load rsp_valid exactly 2 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-036 After REQ-035, store 0x000000AA to 0x10 with wstrb=0001, then load 0x10 -> rsp_rdata=0xDEADBEAA.
REQ-037 Load addr 0x13 (misaligned), then store to addr 0x400 with DEPTH=256 -> both responses rsp_err=1 and rsp_rdata=0; a following load of word 0 is unchanged.
REQ-038 Hold rsp_ready=0 for 5 cycles during RESP with req_valid=1 -> rsp_valid and rsp_rdata stay stable, req_ready=0 throughout, and no second acceptance occurs.
REQ-039 Accept a store of 0x12345678 to 0x20, assert reset in BUSY, then load 0x20 -> old contents returned, and rsp_valid=0 in the cycle after reset.
REQ-040 Hold active=0 with req_valid=1 -> req_ready=0 and no response; raise active -> the request is accepted on the next edge.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed request-to-response latency.
// Stores commit and load data is captured on the edge that enters the response state.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [29:0] DepthW  = 30'(DEPTH);
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          addr_err;
  logic          commit;
  logic          cur_write;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_wstrb;
  logic [AW-1:0] idx;

  assign req_ready = (state_q == StIdle) && active;
  assign accept    = req_valid && req_ready;

  // With LATENCY=1 the response is formed on the acceptance edge, so use the live request.
  always_comb begin
    cur_write = write_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_wstrb = wstrb_q;
    if (state_q == StIdle) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_wstrb = req_wstrb;
    end
  end

  assign enter_resp = ((state_q == StIdle) && accept && (LATENCY == 1)) ||
                      ((state_q == StBusy) && (cnt_q == 4'd1));
  assign addr_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= DepthW);
  assign idx        = cur_addr[AW+1:2];
  assign commit     = enter_resp && cur_write && !addr_err && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StBusy;
              cnt_q   <= CntLoad;
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= addr_err;
        rsp_rdata <= (!cur_write && !addr_err) ? mem[idx] : 32'd0;
      end
    end
  end

  // Array is deliberately not reset; only enabled lanes of a valid store are written.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wstrb[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  logic        t_write;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_wstrb;
  logic        t_ok;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait (bounded) until it is accepted.
  task automatic start_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int waited;
    t_write = wr; t_addr = a; t_wdata = d; t_wstrb = s;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    #1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    t_ok = req_ready;
    if (!t_ok) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble inputs: the accepted request must already be latched.
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
  endtask

  // Wait LATENCY edges, compare against the model, optionally stall, then handshake.
  task automatic finish_rsp(input int hold);
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] w;
    if (!t_ok) return;
    for (int k = 1; k <= LATENCY; k++) begin
      if (k > 1) tick();
      if (k < LATENCY) begin
        check("busy_rsp_valid", 32'(rsp_valid), 32'd0);
        check("busy_req_ready", 32'(req_ready), 32'd0);
      end
    end
    check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    exp_err   = (t_addr % 4 != 0) || ((t_addr / 4) >= DEPTH);
    exp_rdata = 32'd0;
    if (!exp_err) begin
      w = model_mem[t_addr / 4];
      if (t_write) begin
        for (int b = 0; b < 4; b++)
          if (t_wstrb[b]) w[8*b +: 8] = t_wdata[8*b +: 8];
        model_mem[t_addr / 4] = w;
      end else begin
        exp_rdata = w;
      end
    end
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0004;
      tick();
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_rdata", rsp_rdata, exp_rdata);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_rsp_rdata", rsp_rdata, 32'd0);
    check("idle_rsp_err", 32'(rsp_err), 32'd0);
  endtask

  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int hold);
    start_req(wr, a, d, s);
    finish_rsp(hold);
  endtask

  initial begin
    logic [31:0] a;
    // Reset behaviour and req_ready tracking active.
    tick(); tick();
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    tick();
    check("ready_active0", 32'(req_ready), 32'd0);
    active = 1'b1;
    #1;
    check("ready_active1", 32'(req_ready), 32'd1);

    // Fill the whole array so every later load has a known expectation.
    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    // Full-word store and load-back.
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xact(1'b0, 32'h10, 32'd0, 4'h0, 0);
    check("deadbeef_model", model_mem[4], 32'hDEADBEEF);
    // Partial-lane store merges.
    xact(1'b1, 32'h10, 32'h000000AA, 4'h1, 0);
    xact(1'b0, 32'h10, 32'd0, 4'h0, 0);
    check("merge_model", model_mem[4], 32'hDEADBEAA);
    // Empty-strobe store leaves the word alone.
    xact(1'b1, 32'h10, 32'h11111111, 4'h0, 0);
    xact(1'b0, 32'h10, 32'd0, 4'h0, 0);
    // Misaligned load and out-of-range store, then word 0 untouched.
    xact(1'b0, 32'h13, 32'd0, 4'h0, 0);
    xact(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0);
    xact(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 0);
    xact(1'b0, 32'h0, 32'd0, 4'h0, 0);
    // Stalled response with a competing request pending.
    xact(1'b0, 32'h10, 32'd0, 4'h0, 5);
    for (int i = 0; i < LATENCY + 1; i++) begin
      tick();
      check("no_second_accept", 32'(rsp_valid), 32'd0);
    end

    // Reset during BUSY aborts the store.
    start_req(1'b1, 32'h20, 32'h12345678, 4'hF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    tick();
    check("abort_rsp_valid2", 32'(rsp_valid), 32'd0);
    xact(1'b0, 32'h20, 32'd0, 4'h0, 0);

    // active=0 blocks acceptance.
    active = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("inactive_ready", 32'(req_ready), 32'd0);
      check("inactive_rsp", 32'(rsp_valid), 32'd0);
    end
    active = 1'b1;
    xact(1'b0, 32'h10, 32'd0, 4'h0, 0);

    // Randomized traffic, occasionally misaligned or out of range.
    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, DEPTH + 15)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
